seq_divider_8: RTL

Sequential unsigned restoring divider. It is the inverse-operation companion to the team's combinational Dadda multiplier. It accepts an 8-bit dividend and an 8-bit divisor over a valid/ready handshake and retires one quotient bit per clock. It returns quotient and remainder over a second valid/ready handshake. It sits beside the multiplier in the arithmetic datapath and serves as the multiplier's self-check partner: product / operand == other operand.

---
 rtl/seq_divider_8.sv | 131 +++++++++++++
 1 files changed

// File: rtl/seq_divider_8.sv
// Purpose: unsigned restoring divider, W-bit dividend/divisor, one quotient bit retired per clock.
// Latency: result valid W+1 cycles after input acceptance; issue interval W+2 cycles with out_ready high.
// Backpressure: in_ready only in IDLE; DONE holds quotient/remainder until out_ready is seen.
module seq_divider_8 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = $clog2(W) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // a_reg starts as the dividend and shifts left each iteration; the freed
  // LSBs collect quotient bits, so after W steps it holds the full quotient.
  logic [W-1:0]  a_reg;
  logic [W-1:0]  d_reg;
  // The partial remainder stays below the divisor (or below 2^W when the
  // divisor is zero), so only the trial subtraction needs the extra bit.
  logic [W-1:0]  r_reg;
  logic [CW-1:0] count;
  logic          dbz_int;

  logic [W:0]    shifted;
  logic [W:0]    trial;
  logic [W-1:0]  r_nxt;
  logic          q_bit;
  logic          accept;
  logic          last_iter;

  assign accept    = (state == IDLE) && in_valid;
  assign last_iter = (count == CW'(W - 1));

  // One restoring step: bring down the next dividend bit and try the subtraction.
  always_comb begin
    shifted = {r_reg, a_reg[W-1]};
    trial   = shifted - {1'b0, d_reg};
    q_bit   = ~trial[W];
    r_nxt   = q_bit ? trial[W-1:0] : shifted[W-1:0];
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; handshake outputs decode the state register only.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (last_iter) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Iteration registers: load on acceptance, one quotient bit per RUN cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg   <= '0;
      d_reg   <= '0;
      r_reg   <= '0;
      count   <= '0;
      dbz_int <= 1'b0;
    end else if (accept) begin
      a_reg   <= dividend;
      d_reg   <= divisor;
      r_reg   <= '0;
      count   <= '0;
      dbz_int <= (divisor == '0);
    end else if (state == RUN) begin
      a_reg <= {a_reg[W-2:0], q_bit};
      r_reg <= r_nxt;
      count <= count + 1'b1;
    end
  end

  // Result registers: written only on the final iteration, held otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if ((state == RUN) && last_iter) begin
      quotient    <= {a_reg[W-2:0], q_bit};
      remainder   <= r_nxt;
      div_by_zero <= dbz_int;
    end
  end

endmodule
